conv_mdc_tile_sched: RTL and testbench

Row-tile scheduler for the conv_mdc convolution datapath. It sits between the controller FSM and the src_V/dst_V streamers and engine. It splits a width x height frame into horizontal tiles of TILE_H output rows, adding a (K-1)-row input halo. For each tile it issues one source and one sink transfer request, then starts the engine and waits for both completions before moving to the next tile.

---
 rtl/conv_mdc_package.sv | 24 ++
 rtl/conv_mdc_tile_req_if.sv | 29 ++
 rtl/conv_mdc_tile_sched.sv | 207 ++++++++++++++++++++
 tb/tb_conv_mdc_tile_sched.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_mdc_package.sv
// Shared types and constants for the conv_mdc row-tile scheduler.
package conv_mdc_package;

  localparam int REQ_ADDR_W = 32;
  localparam int REQ_SIZE_W = 32;

  // Register-map index of the tile_h configuration word.
  localparam int CONV_MDC_REG_TILE_H = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ISSUE,
    ST_RUN,
    ST_NEXT,
    ST_FIN
  } tile_sched_state_e;

  typedef struct packed {
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_SIZE_W-1:0] size;
  } tile_req_t;

endpackage

// File: rtl/conv_mdc_tile_req_if.sv
// One valid/ready request slot: loaded by the scheduler, held stable until
// the streamer accepts it.
module conv_mdc_tile_req_if
  import conv_mdc_package::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      load,
  input  tile_req_t load_req,
  input  logic      ready,
  output logic      valid,
  output tile_req_t req
);

  // Request register: set on load, drop valid only once the streamer takes it.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      valid <= 1'b0;
      req   <= '0;
    end else if (load) begin
      valid <= 1'b1;
      req   <= load_req;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/conv_mdc_tile_sched.sv
// Row-tile scheduler: splits a frame into TILE_H-row tiles with a (K-1)-row
// input halo, issues src/dst requests per tile and sequences the engine.
module conv_mdc_tile_sched
  import conv_mdc_package::*;
#(
  parameter int ADDR_W = REQ_ADDR_W,
  parameter int DIM_W  = 16,
  parameter int BPP    = 4,
  parameter int K      = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic [DIM_W-1:0]  width_i,
  input  logic [DIM_W-1:0]  height_i,
  input  logic [DIM_W-1:0]  tile_h_i,
  input  logic [ADDR_W-1:0] src_base_i,
  input  logic [ADDR_W-1:0] dst_base_i,
  output logic              src_req_valid_o,
  input  logic              src_req_ready_i,
  output logic [ADDR_W-1:0] src_addr_o,
  output logic [31:0]       src_size_o,
  output logic              dst_req_valid_o,
  input  logic              dst_req_ready_i,
  output logic [ADDR_W-1:0] dst_addr_o,
  output logic [31:0]       dst_size_o,
  output logic              eng_start_o,
  input  logic              eng_done_i,
  input  logic              dst_done_i,
  output logic              busy_o,
  output logic [DIM_W-1:0]  tile_idx_o,
  output logic              done_o,
  output logic              err_o
);

  localparam logic [DIM_W:0] HALO = (DIM_W+1)'(K - 1);

  tile_sched_state_e state, state_next;

  logic              rst_all;
  logic [DIM_W-1:0]  width_q, height_q, tile_h_q, tile_idx_q;
  logic [ADDR_W-1:0] src_addr_q, dst_addr_q, src_addr_nx, dst_addr_nx;
  logic [31:0]       tile_words_q, step;
  logic [DIM_W:0]    r0_q, r0_sum, r0_entry, rem, n_out, n_in;
  logic              eng_seen_q, dst_seen_q, err_q, done_q, eng_start_q;
  logic              cfg_bad, all_acc, load_req, start_ok, done_d, eng_start_d;
  logic              src_valid, dst_valid;
  tile_req_t         src_req_d, dst_req_d, src_req_q, dst_req_q;

  assign rst_all = rst_i | clear_i;
  assign cfg_bad = (width_i == '0) || (height_i == '0) || (tile_h_i == '0);
  assign all_acc = (!src_valid || src_req_ready_i) && (!dst_valid || dst_req_ready_i);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_all) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Next-state and control strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next  = state;
    load_req    = 1'b0;
    start_ok    = 1'b0;
    done_d      = 1'b0;
    eng_start_d = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          if (cfg_bad) begin
            done_d = 1'b1;
          end else begin
            start_ok   = 1'b1;
            state_next = ST_SETUP;
          end
        end
      end
      ST_SETUP: begin
        load_req   = 1'b1;
        state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (all_acc) begin
          eng_start_d = 1'b1;
          state_next  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (eng_seen_q && dst_seen_q) state_next = ST_NEXT;
      end
      ST_NEXT: begin
        if (r0_sum >= {1'b0, height_q}) begin
          state_next = ST_FIN;
        end else begin
          load_req   = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_FIN: begin
        done_d     = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Tile geometry for the request about to be loaded: in NEXT it describes the
  // following tile, so it is computed from the advanced row and addresses.
  always_comb begin
    r0_sum      = r0_q + {1'b0, tile_h_q};
    r0_entry    = (state == ST_NEXT) ? r0_sum : r0_q;
    rem         = {1'b0, height_q} - r0_entry;
    n_out       = ({1'b0, tile_h_q} < rem) ? {1'b0, tile_h_q} : rem;
    n_in        = ((n_out + HALO) < rem) ? (n_out + HALO) : rem;
    step        = tile_words_q * 32'(BPP);
    src_addr_nx = (state == ST_NEXT) ? src_addr_q + ADDR_W'(step) : src_addr_q;
    dst_addr_nx = (state == ST_NEXT) ? dst_addr_q + ADDR_W'(step) : dst_addr_q;
    src_req_d.addr = REQ_ADDR_W'(src_addr_nx);
    src_req_d.size = 32'(n_in) * 32'(width_q);
    dst_req_d.addr = REQ_ADDR_W'(dst_addr_nx);
    dst_req_d.size = 32'(n_out) * 32'(width_q);
  end

  // Job configuration, tile counters, completion flags and output pulses.
  always_ff @(posedge clk_i) begin
    if (rst_all) begin
      width_q      <= '0;
      height_q     <= '0;
      tile_h_q     <= '0;
      src_addr_q   <= '0;
      dst_addr_q   <= '0;
      tile_words_q <= '0;
      r0_q         <= '0;
      tile_idx_q   <= '0;
      eng_seen_q   <= 1'b0;
      dst_seen_q   <= 1'b0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      eng_start_q  <= 1'b0;
    end else begin
      done_q      <= done_d;
      eng_start_q <= eng_start_d;
      if (state == ST_IDLE && start_i) begin
        err_q <= cfg_bad;
        if (start_ok) begin
          width_q    <= width_i;
          height_q   <= height_i;
          tile_h_q   <= tile_h_i;
          src_addr_q <= src_base_i;
          dst_addr_q <= dst_base_i;
          r0_q       <= '0;
          tile_idx_q <= '0;
          eng_seen_q <= 1'b0;
          dst_seen_q <= 1'b0;
        end
      end
      if (state == ST_SETUP) tile_words_q <= 32'(tile_h_q) * 32'(width_q);
      if (state == ST_RUN) begin
        if (eng_done_i) eng_seen_q <= 1'b1;
        if (dst_done_i) dst_seen_q <= 1'b1;
      end
      if (state == ST_NEXT) begin
        r0_q       <= r0_sum;
        tile_idx_q <= tile_idx_q + 1'b1;
        src_addr_q <= src_addr_nx;
        dst_addr_q <= dst_addr_nx;
        eng_seen_q <= 1'b0;
        dst_seen_q <= 1'b0;
      end
    end
  end

  conv_mdc_tile_req_if u_src_req (
    .clk      (clk_i),
    .rst      (rst_all),
    .load     (load_req),
    .load_req (src_req_d),
    .ready    (src_req_ready_i),
    .valid    (src_valid),
    .req      (src_req_q)
  );

  conv_mdc_tile_req_if u_dst_req (
    .clk      (clk_i),
    .rst      (rst_all),
    .load     (load_req),
    .load_req (dst_req_d),
    .ready    (dst_req_ready_i),
    .valid    (dst_valid),
    .req      (dst_req_q)
  );

  assign src_req_valid_o = src_valid;
  assign src_addr_o      = ADDR_W'(src_req_q.addr);
  assign src_size_o      = src_req_q.size;
  assign dst_req_valid_o = dst_valid;
  assign dst_addr_o      = ADDR_W'(dst_req_q.addr);
  assign dst_size_o      = dst_req_q.size;
  assign eng_start_o     = eng_start_q;
  assign busy_o          = (state != ST_IDLE);
  assign tile_idx_o      = tile_idx_q;
  assign done_o          = done_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_conv_mdc_tile_sched.sv
// Scoreboard bench for conv_mdc_tile_sched: a frame-level model pushes the
// expected tile requests and job outcomes; a monitor pops and compares them.
module tb_conv_mdc_tile_sched;

  localparam int BPP = 4;
  localparam int K   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1, clear = 1'b0, start = 1'b0;
  logic [15:0] width = '0, height = '0, tile_h = '0;
  logic [31:0] src_base = '0, dst_base = '0;
  logic        src_ready = 1'b0, dst_ready = 1'b0, eng_done = 1'b0, dst_done = 1'b0;
  logic        src_valid, dst_valid, eng_start, busy, done, err;
  logic [31:0] src_addr, src_size, dst_addr, dst_size;
  logic [15:0] tile_idx;

  always #5 clk = ~clk;

  conv_mdc_tile_sched dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .clear_i         (clear),
    .start_i         (start),
    .width_i         (width),
    .height_i        (height),
    .tile_h_i        (tile_h),
    .src_base_i      (src_base),
    .dst_base_i      (dst_base),
    .src_req_valid_o (src_valid),
    .src_req_ready_i (src_ready),
    .src_addr_o      (src_addr),
    .src_size_o      (src_size),
    .dst_req_valid_o (dst_valid),
    .dst_req_ready_i (dst_ready),
    .dst_addr_o      (dst_addr),
    .dst_size_o      (dst_size),
    .eng_start_o     (eng_start),
    .eng_done_i      (eng_done),
    .dst_done_i      (dst_done),
    .busy_o          (busy),
    .tile_idx_o      (tile_idx),
    .done_o          (done),
    .err_o           (err)
  );

  typedef struct { logic [31:0] addr; logic [31:0] size; int tile; } req_t;
  typedef struct { bit err; int tiles; } job_t;

  req_t exp_src[$], exp_dst[$];
  job_t exp_job[$];

  int checks = 0, errors = 0;
  int src_dly_cfg = 0, dst_dly_cfg = 0;  // 0: ready tied high, -1: random, n: wait n cycles
  int eng_rsp_cfg = 5, dst_rsp_cfg = 5;  // 0: random 1..6, n: pulse n cycles after eng_start
  int done_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Frame-level reference: walk output rows in steps of tile_h.
  task automatic push_model(input int w, input int h, input int th,
                            input logic [31:0] sb, input logic [31:0] db);
    int r0 = 0;
    int t  = 0;
    int n_out, n_in;
    if (w == 0 || h == 0 || th == 0) begin
      exp_job.push_back('{err: 1'b1, tiles: 0});
      return;
    end
    while (r0 < h) begin
      n_out = (th < h - r0) ? th : h - r0;
      n_in  = (n_out + K - 1 < h - r0) ? n_out + K - 1 : h - r0;
      exp_src.push_back('{addr: sb + 32'(r0 * w * BPP), size: 32'(n_in * w), tile: t});
      exp_dst.push_back('{addr: db + 32'(r0 * w * BPP), size: 32'(n_out * w), tile: t});
      r0 += th;
      t++;
    end
    exp_job.push_back('{err: 1'b0, tiles: t});
  endtask

  task automatic start_job(input int w, input int h, input int th,
                           input logic [31:0] sb, input logic [31:0] db, input bit lat);
    @(posedge clk); #1;
    width = 16'(w); height = 16'(h); tile_h = 16'(th);
    src_base = sb; dst_base = db;
    start = 1'b1;
    if (lat) begin @(negedge clk); check("lat_cycle0_src_valid", 64'(src_valid), 64'(0)); end
    @(posedge clk); #1;
    start = 1'b0;
    if (lat) begin
      @(negedge clk); check("lat_cycle1_src_valid", 64'(src_valid), 64'(0));
      @(negedge clk); check("lat_cycle2_src_valid", 64'(src_valid), 64'(1));
      check("lat_cycle2_dst_valid", 64'(dst_valid), 64'(1));
    end
  endtask

  task automatic wait_done(input int base);
    int n = 0;
    while (done_seen == base && n < 3000) begin @(negedge clk); n++; end
    if (done_seen == base) begin
      checks++; errors++;
      $display("FAIL job_timeout: done_o not seen within %0d cycles", n);
    end
  endtask

  task automatic run_job(input int w, input int h, input int th,
                         input logic [31:0] sb, input logic [31:0] db,
                         input int e_rsp, input int d_rsp, input int s_dly, input int d_dly,
                         input bit lat);
    int base;
    eng_rsp_cfg = e_rsp; dst_rsp_cfg = d_rsp;
    src_dly_cfg = s_dly; dst_dly_cfg = d_dly;
    push_model(w, h, th, sb, db);
    base = done_seen;
    start_job(w, h, th, sb, db, lat);
    wait_done(base);
    repeat (3) @(posedge clk);
  endtask

  // Source ready driver.
  int src_cnt = 0, src_need = 0;
  always @(posedge clk) begin
    #1;
    if (src_dly_cfg == 0) src_ready = 1'b1;
    else if (src_valid) begin
      if (src_cnt == 0) src_need = (src_dly_cfg < 0) ? int'($urandom_range(0, 4)) : src_dly_cfg;
      src_ready = (src_cnt >= src_need);
      src_cnt++;
    end else begin
      src_cnt = 0; src_ready = 1'b0;
    end
  end

  // Sink ready driver.
  int dst_cnt = 0, dst_need = 0;
  always @(posedge clk) begin
    #1;
    if (dst_dly_cfg == 0) dst_ready = 1'b1;
    else if (dst_valid) begin
      if (dst_cnt == 0) dst_need = (dst_dly_cfg < 0) ? int'($urandom_range(0, 4)) : dst_dly_cfg;
      dst_ready = (dst_cnt >= dst_need);
      dst_cnt++;
    end else begin
      dst_cnt = 0; dst_ready = 1'b0;
    end
  end

  // Engine / sink completion responder: one pulse each per observed eng_start.
  int eng_left = 0, dst_left = 0;
  always @(negedge clk) begin
    eng_done = 1'b0;
    dst_done = 1'b0;
    if (rst || clear) begin
      eng_left = 0; dst_left = 0;
    end else begin
      if (eng_left > 0) begin eng_left--; if (eng_left == 0) eng_done = 1'b1; end
      if (dst_left > 0) begin dst_left--; if (dst_left == 0) dst_done = 1'b1; end
      if (eng_start) begin
        eng_left = (eng_rsp_cfg > 0) ? eng_rsp_cfg : int'($urandom_range(1, 6));
        dst_left = (dst_rsp_cfg > 0) ? dst_rsp_cfg : int'($urandom_range(1, 6));
      end
    end
  end

  // Monitor: request handshakes, hold rules, engine start ordering, job end.
  int   cyc = 0, last_acc_cyc = -10, src_acc = 0, dst_acc = 0, eng_starts = 0, job_tiles = 0;
  logic p_sv = 1'b0, p_sr = 1'b0, p_dv = 1'b0, p_dr = 1'b0;
  logic [31:0] p_sa = '0, p_ss = '0, p_da = '0, p_ds = '0;
  req_t e;
  job_t j;
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (p_sv && !p_sr) begin
        check("src_valid_held", 64'(src_valid), 64'(1));
        check("src_req_stable", {src_addr, src_size}, {p_sa, p_ss});
      end
      if (p_dv && !p_dr) begin
        check("dst_valid_held", 64'(dst_valid), 64'(1));
        check("dst_req_stable", {dst_addr, dst_size}, {p_da, p_ds});
      end
      if (src_valid && src_ready) begin
        if (exp_src.size() == 0) begin
          checks++; errors++;
          $display("FAIL src_req_unexpected: addr 0x%0h size %0d, none expected", src_addr, src_size);
        end else begin
          e = exp_src.pop_front();
          check("src_addr", 64'(src_addr), 64'(e.addr));
          check("src_size", 64'(src_size), 64'(e.size));
          check("src_tile_idx", 64'(tile_idx), 64'(e.tile));
        end
        src_acc++; job_tiles++; last_acc_cyc = cyc;
      end
      if (dst_valid && dst_ready) begin
        if (exp_dst.size() == 0) begin
          checks++; errors++;
          $display("FAIL dst_req_unexpected: addr 0x%0h size %0d, none expected", dst_addr, dst_size);
        end else begin
          e = exp_dst.pop_front();
          check("dst_addr", 64'(dst_addr), 64'(e.addr));
          check("dst_size", 64'(dst_size), 64'(e.size));
        end
        dst_acc++; last_acc_cyc = cyc;
      end
      if (eng_start) begin
        eng_starts++;
        check("eng_start_cycle_after_accept", 64'(cyc - last_acc_cyc), 64'(1));
        check("eng_start_vs_src_accepts", 64'(src_acc), 64'(eng_starts));
        check("eng_start_vs_dst_accepts", 64'(dst_acc), 64'(eng_starts));
      end
      if (done) begin
        check("done_busy_low", 64'(busy), 64'(0));
        if (exp_job.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected: done_o pulsed with no job pending");
        end else begin
          j = exp_job.pop_front();
          check("done_err", 64'(err), 64'(j.err));
          check("done_tile_count", 64'(job_tiles), 64'(j.tiles));
        end
        job_tiles = 0;
        done_seen++;
      end
      if (clear) begin
        exp_src.delete(); exp_dst.delete(); exp_job.delete();
        job_tiles = 0;
      end
    end
    p_sv = src_valid; p_sr = src_ready; p_sa = src_addr; p_ss = src_size;
    p_dv = dst_valid; p_dr = dst_ready; p_da = dst_addr; p_ds = dst_size;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_valids", {62'd0, src_valid, dst_valid}, 64'(0));
    check("reset_pulses", {61'd0, eng_start, done, err}, 64'(0));
    check("reset_tile_idx", 64'(tile_idx), 64'(0));
    check("reset_src_req", {src_addr, src_size}, 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Two tiles, second source clipped at the frame bottom; start latency.
    run_job(8, 8, 4, 32'h1000, 32'h2000, 5, 5, 0, 0, 1'b1);
    // Partial last tile; both completions in the same cycle.
    run_job(8, 10, 4, 32'h4000, 32'h8000, 3, 3, 0, 0, 1'b0);
    // Delayed readies; engine done before sink done.
    run_job(8, 10, 4, 32'h1000, 32'h2000, 2, 6, 3, 1, 1'b0);
    // Sink done before engine done.
    run_job(8, 10, 4, 32'h1000, 32'h2000, 6, 2, 1, 3, 1'b0);

    // Zero-dimension configurations.
    run_job(8, 8, 0, 32'h1000, 32'h2000, 5, 5, 0, 0, 1'b0);
    @(negedge clk);
    check("err_sticky", 64'(err), 64'(1));
    check("err_job_busy", 64'(busy), 64'(0));
    run_job(0, 8, 4, 32'h1000, 32'h2000, 5, 5, 0, 0, 1'b0);

    // Clear in the middle of RUN, then a fresh job from tile 0.
    eng_rsp_cfg = 20; dst_rsp_cfg = 20; src_dly_cfg = 0; dst_dly_cfg = 0;
    push_model(8, 16, 4, 32'h3000, 32'h5000);
    start_job(8, 16, 4, 32'h3000, 32'h5000, 1'b0);
    n = 0;
    while (!eng_start && n < 100) begin @(posedge clk); #1; n++; end
    check("clear_setup_reached_run", 64'(eng_start), 64'(1));
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    check("clear_busy", 64'(busy), 64'(0));
    check("clear_valids", {62'd0, src_valid, dst_valid}, 64'(0));
    check("clear_tile_idx", 64'(tile_idx), 64'(0));
    run_job(8, 8, 4, 32'h1000, 32'h2000, 5, 5, 0, 0, 1'b0);

    // Randomized frames, including address wrap and oversize tiles.
    for (int i = 0; i < 12; i++) begin
      run_job(int'($urandom_range(1, 12)), int'($urandom_range(1, 20)), int'($urandom_range(1, 24)),
              (i % 3 == 0) ? 32'hFFFF_FF00 + $urandom_range(0, 255) : $urandom(), $urandom(),
              0, 0, -1, -1, 1'b0);
    end

    check("src_queue_drained", 64'(exp_src.size()), 64'(0));
    check("dst_queue_drained", 64'(exp_dst.size()), 64'(0));
    check("job_queue_drained", 64'(exp_job.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
